axi4_lite_slave_regfile: RTL and testbench
==========================================

Name: axi4_lite_slave_regfile

Overview:
AXI4-Lite responder holding a bank of NUM_REGS 32-bit read/write registers, word-addressed from address 0. It is the far end of the team's AXI4-Lite master: it accepts AW/W/B write transactions and AR/R read transactions and returns OKAY or SLVERR responses. Read and write channels run on independent state machines and may be active at the same time.

Parameters:
DATA_WIDTH, 32, data bus and register width.
ADDR_WIDTH, 32, address bus width.
NUM_REGS, 8, number of registers; power of two, at least 2.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
awvalid  input  1  write address valid.
awaddr  input  ADDR_WIDTH  write byte address.
awready  output  1  write address ready.
wvalid  input  1  write data valid.
wdata  input  DATA_WIDTH  write data.
wready  output  1  write data ready.
bvalid  output  1  write response valid.
bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
bready  input  1  write response ready.
arvalid  input  1  read address valid.
araddr  input  ADDR_WIDTH  read byte address.
arready  output  1  read address ready.
rvalid  output  1  read data valid.
rdata  output  DATA_WIDTH  read data.
rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
rready  input  1  read data ready.

Behaviour:
- Reset (reset low, asynchronous): all registers go to 0. awready, wready, arready, bvalid and rvalid go to 0. bresp, rresp and rdata go to 0. Both FSMs go to idle. The three readies are registered and rise on the first clk edge after reset deasserts.
- Address decode: index = addr[IDX_W+1:2], where IDX_W = log2(NUM_REGS). An address is valid only if addr[1:0]==0 and addr < NUM_REGS*4. Any other address gets SLVERR.
- Write FSM, W_IDLE:
  - AW and W are accepted independently and in either order.
  - awready = W_IDLE and no AW held. wready = W_IDLE and no W held.
  - A handshake (valid && ready) latches the address or data and sets the matching held flag. The matching ready drops on the next cycle.
  - In the cycle where both are held, or both handshake together, the FSM commits. A valid address writes the register; an invalid address writes nothing. bresp is set, bvalid is set, and the FSM moves to W_RESP. Both commit effects and bvalid appear at the next edge.
  - Latency: AW and W handshaking in the same cycle N gives bvalid=1 and the updated register at cycle N+1.
- Write FSM, W_RESP: bvalid is held, with bresp stable, until bready=1. At the handshake edge: bvalid=0, held flags cleared, FSM returns to W_IDLE, and awready/wready rise at that same edge.
- Read FSM, R_IDLE: arready=1. An AR handshake in cycle N registers rdata and rresp, sets rvalid=1 at N+1 and moves to R_RESP.
  - Valid address: rdata = register contents, rresp = OKAY.
  - Invalid address: rdata = 0, rresp = SLVERR.
- Read FSM, R_RESP: arready=0. rvalid, rdata and rresp are held stable until rready=1. On the handshake: rvalid=0, FSM returns to R_IDLE, arready=1 at that edge.
- Read and write at the same time:
  - A read capture and a write commit to the same index on the same edge returns the OLD value.
  - A read one cycle or more after the commit returns the NEW value.
- Back-pressure: if bready or rready stays low, the response is held indefinitely and no new address on that channel is accepted.
- Reset mid-transaction: held AW/W, pending responses and the FSMs are discarded at once. The register contents revert to 0.
- Compatibility with a one-cycle valid pulse: the master drops valid on the cycle after it sees ready. The idle-high readies guarantee the handshake completes within that pulse.

Test Plan:
- Reset, write 0xDEADBEEF to 0x4 (AW and W in the same cycle), then read 0x4 -> bvalid=1 at N+1 with bresp=00; rvalid=1 one cycle after AR with rdata=0xDEADBEEF and rresp=00. Read 0x0 -> 0x00000000.
- W sent 3 cycles before AW (address 0x8, data 0x12345678) -> wready low after the W handshake; bvalid one cycle after the AW handshake; a read of 0x8 returns 0x12345678.
- Write to 0x20 with NUM_REGS=8, write to 0x6, read 0x40 -> bresp=10 for both writes; no register changes (all 8 still read back their previous values); rresp=10 with rdata=0.
- Hold bready=0 for 5 cycles after a write to 0x0; offer a second AW meanwhile -> bvalid stays 1 with bresp stable; awready stays 0; the second AW is accepted only after the B handshake.
- Read 0xC on the same edge as a committing write of 0xA5A5A5A5 to 0xC (old value 0x1) -> rdata=0x00000001; the next read returns 0xA5A5A5A5.
- Pull reset low while bvalid=1 and rvalid=1 are pending -> all valids and readies go to 0 immediately; all registers read 0 after release; readies return 1 one edge after release.

Source files
------------

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder with a bank of NUM_REGS read/write registers.
// The read and write channels run on independent two-state FSMs.
module axi4_lite_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  awvalid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awready,
    input  logic                  wvalid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wready,
    output logic                  bvalid,
    output logic [1:0]            bresp,
    input  logic                  bready,
    input  logic                  arvalid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic                  rready
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic aw_hs, w_hs, ar_hs;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid && wready_q;
    assign ar_hs = arvalid && arready_q;

    // Write channel: collect AW and W in any order, commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                end
                if (aw_held_d && w_held_d) begin
                    if (addr_ok(awaddr_d)) begin
                        regs_d[addr_idx(awaddr_d)] = wdata_d;
                    end
                    bresp_d   = addr_ok(awaddr_d) ? OKAY : SLVERR;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: ;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read channel: capture on AR handshake, hold response until rready.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = addr_ok(araddr) ? regs_q[addr_idx(araddr)] : '0;
                    rresp_d   = addr_ok(araddr) ? OKAY : SLVERR;
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: ;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State, handshake and register-bank update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_axi4_lite_slave_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [1:0]  bresp, rresp;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [8];
    logic [31:0] rd_d;
    logic [1:0]  rsp;

    axi4_lite_slave_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .NUM_REGS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .awvalid(awvalid),
        .awaddr(awaddr),
        .awready(awready),
        .wvalid(wvalid),
        .wdata(wdata),
        .wready(wready),
        .bvalid(bvalid),
        .bresp(bresp),
        .bready(bready),
        .arvalid(arvalid),
        .araddr(araddr),
        .arready(arready),
        .rvalid(rvalid),
        .rdata(rdata),
        .rresp(rresp),
        .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            output logic [1:0] resp);
        logic ah, wh, ok;
        ok = 1'b0;
        awaddr = a; wdata = d;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            step();
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
            if (!awvalid && !wvalid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr_hs_done", 32'(ok), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid_lat", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
        logic ok;
        ok = 1'b0;
        araddr = a;
        arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (arready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("rd_ar_ready", 32'(ok), 32'd1);
        step();
        arvalid = 1'b0;
        chk("rd_rvalid_lat", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; araddr = 0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;

        // Reset state
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        step();
        step();
        reset = 1'b1;
        chk("rel_awready_low", 32'(awready), 32'd0);
        step();
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_wready", 32'(wready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);

        // Basic write and read
        do_write(32'h4, 32'hDEADBEEF, rsp);
        model[1] = 32'hDEADBEEF;
        chk("w4_bresp", 32'(rsp), 32'd0);
        do_read(32'h4, rd_d, rsp);
        chk("r4_data", rd_d, 32'hDEADBEEF);
        chk("r4_rresp", 32'(rsp), 32'd0);
        do_read(32'h0, rd_d, rsp);
        chk("r0_data", rd_d, 32'h0);

        // W three cycles ahead of AW
        wdata = 32'h12345678;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("wfirst_wready", 32'(wready), 32'd0);
        chk("wfirst_awready", 32'(awready), 32'd1);
        step();
        step();
        chk("wfirst_no_b", 32'(bvalid), 32'd0);
        awaddr = 32'h8;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("wfirst_bvalid", 32'(bvalid), 32'd1);
        chk("wfirst_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        model[2] = 32'h12345678;
        do_read(32'h8, rd_d, rsp);
        chk("r8_data", rd_d, 32'h12345678);

        // B back-pressure with a second AW waiting
        awaddr = 32'h0; wdata = 32'h11111111;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        chk("bp_bvalid", 32'(bvalid), 32'd1);
        awaddr = 32'h10; wdata = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_bvalid_hold", 32'(bvalid), 32'd1);
            chk("bp_bresp_hold", 32'(bresp), 32'd0);
            chk("bp_awready_low", 32'(awready), 32'd0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bp_b_done", 32'(bvalid), 32'd0);
        chk("bp_awready_back", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_b", 32'(bvalid), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        model[0] = 32'h11111111;
        model[4] = 32'h22222222;

        // Invalid addresses
        do_write(32'h20, 32'hBAD0BAD0, rsp);
        chk("w20_bresp", 32'(rsp), 32'd2);
        do_write(32'h6, 32'hBAD1BAD1, rsp);
        chk("w6_bresp", 32'(rsp), 32'd2);
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4), rd_d, rsp);
            chk($sformatf("bank_r%0d", i), rd_d, model[i]);
        end
        do_read(32'h40, rd_d, rsp);
        chk("r40_rresp", 32'(rsp), 32'd2);
        chk("r40_rdata", rd_d, 32'h0);

        // Read and commit on the same edge
        do_write(32'hC, 32'h1, rsp);
        awaddr = 32'hC; wdata = 32'hA5A5A5A5; araddr = 32'hC;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_rvalid", 32'(rvalid), 32'd1);
        chk("same_bvalid", 32'(bvalid), 32'd1);
        chk("same_old_data", rdata, 32'h1);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        do_read(32'hC, rd_d, rsp);
        chk("same_new_data", rd_d, 32'hA5A5A5A5);

        // Reset with both responses pending
        awaddr = 32'h10; wdata = 32'h33333333; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("pend_bvalid", 32'(bvalid), 32'd1);
        chk("pend_rvalid", 32'(rvalid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rvalid", 32'(rvalid), 32'd0);
        chk("mid_awready", 32'(awready), 32'd0);
        chk("mid_wready", 32'(wready), 32'd0);
        chk("mid_arready", 32'(arready), 32'd0);
        step();
        reset = 1'b1;
        chk("mid_rel_arready_low", 32'(arready), 32'd0);
        step();
        chk("mid_rel_awready", 32'(awready), 32'd1);
        chk("mid_rel_wready", 32'(wready), 32'd1);
        chk("mid_rel_arready", 32'(arready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4), rd_d, rsp);
            chk($sformatf("post_rst_r%0d", i), rd_d, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
